// File: rtl/shift_reg_seq_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shift_reg_pkg                                                              |
// | Shared state encoding, parameter defaults and a width helper.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package shift_reg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        CHECK = 2'd3
    } state_t;

    localparam int WIDTH_DEFAULT = 4;
    localparam int DIV_DEFAULT   = 2;

    // Counter width for values 0..v-1, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return ($clog2(v) < 1) ? 1 : $clog2(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_reg_seq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shift_reg_seq_ctrl_if                                                      |
// | Host/datapath-facing signal bundle of the shift-register sequencer.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface shift_reg_seq_ctrl_if
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic             Start;
    logic [WIDTH-1:0] Data_In;
    logic [WIDTH-1:0] Q_Fb;
    logic             D;
    logic             Shift_En;
    logic             Busy;
    logic             Done;
    logic             Match;

    modport master (
        output Start, Data_In, Q_Fb,
        input  D, Shift_En, Busy, Done, Match
    );

    modport slave (
        input  Start, Data_In, Q_Fb,
        output D, Shift_En, Busy, Done, Match
    );
endinterface
`default_nettype wire

// File: rtl/shift_reg_for.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shift_reg_for                                                              |
// | Enable-capable serial-in, parallel-out left-shift register.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module shift_reg_for #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             En,
    input  logic             D,
    output logic [WIDTH-1:0] Q
);
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Q <= '0;
        end else if (En) begin
            Q <= {Q[WIDTH-2:0], D};
        end
    end
endmodule
`default_nettype wire

// File: rtl/shift_reg_seq_ctrl_tick_div.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shift_tick_div                                                             |
// | DIV-cycle tick generator with synchronous clear; tick on the last count.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module shift_tick_div
    import shift_reg_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic clr,
    output logic tick
);
    localparam int            DW   = clog2_min1(DIV);
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    logic [DW-1:0] div_cnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            div_cnt <= '0;
        end else if (clr || (div_cnt == LAST)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = !clr && (div_cnt == LAST);
endmodule
`default_nettype wire

// File: rtl/shift_reg_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shift_reg_seq_ctrl                                                         |
// | Serializes a captured word MSB-first into a shift register, then verifies. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module shift_reg_seq_ctrl
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DIV   = DIV_DEFAULT
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    shift_reg_seq_ctrl_if.slave  bus
);
    localparam int            CW       = clog2_min1(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] hold;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    bit_idx;
    logic             done_q;
    logic             match_q;
    logic             div_clr;
    logic             tick;

    assign div_clr = (state != SHIFT);
    assign bit_idx = CNT_LAST - cnt;

    shift_tick_div #(
        .DIV (DIV)
    ) u_tick_div (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .clr   (div_clr),
        .tick  (tick)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        bus.D        = 1'b0;
        bus.Shift_En = 1'b0;
        bus.Busy     = (state != IDLE);
        bus.Done     = done_q;
        bus.Match    = match_q;
        case (state)
            IDLE:  if (bus.Start) state_nx = LOAD;
            LOAD:  state_nx = SHIFT;
            SHIFT: begin
                bus.D        = hold[bit_idx];
                bus.Shift_En = tick;
                if (tick && (cnt == CNT_LAST)) state_nx = CHECK;
            end
            CHECK: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The last shift leaves cnt at WIDTH-1; LOAD clears it for the next word.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hold    <= '0;
            cnt     <= '0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            done_q <= (state == CHECK);
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        hold    <= bus.Data_In;
                        match_q <= 1'b0;
                    end
                end
                LOAD: cnt <= '0;
                SHIFT: begin
                    if (tick && (cnt != CNT_LAST)) cnt <= cnt + 1'b1;
                end
                CHECK: match_q <= (bus.Q_Fb == hold);
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_shift_reg_seq_ctrl.sv
`default_nettype none
// Bench: two sequencer instances (DIV=2 and DIV=1) each driving a shift register;
// traces are compared cycle by cycle against a timing-formula reference model.
module tb_shift_reg_seq_ctrl;
    import shift_reg_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         start_v [2];
    logic [W-1:0] din_v   [2];
    logic         stuck_v [2];
    logic [W-1:0] q0, q1;
    logic [4:0]   obs0, obs1;

    shift_reg_seq_ctrl_if #(.WIDTH(W)) bus0 ();
    shift_reg_seq_ctrl_if #(.WIDTH(W)) bus1 ();

    shift_reg_seq_ctrl #(.WIDTH(W), .DIV(2)) dut0 (.Clk(clk), .Rst_n(rst_n), .bus(bus0.slave));
    shift_reg_seq_ctrl #(.WIDTH(W), .DIV(1)) dut1 (.Clk(clk), .Rst_n(rst_n), .bus(bus1.slave));

    shift_reg_for #(.WIDTH(W)) sr0 (.Clk(clk), .Rst_n(rst_n), .En(bus0.Shift_En), .D(bus0.D), .Q(q0));
    shift_reg_for #(.WIDTH(W)) sr1 (.Clk(clk), .Rst_n(rst_n), .En(bus1.Shift_En), .D(bus1.D), .Q(q1));

    assign bus0.Start   = start_v[0];
    assign bus0.Data_In = din_v[0];
    assign bus0.Q_Fb    = stuck_v[0] ? {q0[W-1:1], 1'b0} : q0;
    assign bus1.Start   = start_v[1];
    assign bus1.Data_In = din_v[1];
    assign bus1.Q_Fb    = stuck_v[1] ? {q1[W-1:1], 1'b0} : q1;

    assign obs0 = {bus0.Busy, bus0.D, bus0.Shift_En, bus0.Done, bus0.Match};
    assign obs1 = {bus1.Busy, bus1.D, bus1.Shift_En, bus1.Done, bus1.Match};

    int n_vec = 0;
    int n_bad = 0;
    logic         last_match [2];
    logic [4:0]   tr  [64];
    logic [W-1:0] trq [64];

    typedef struct {
        int           sel;
        logic [W-1:0] data;
        logic         stuck;
        int           exp_done;
        logic         exp_match;
    } vec_t;
    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic int div_of(input int s);
        return (s == 0) ? 2 : 1;
    endfunction

    // Reference: every output is a function of the cycle offset from the accepted Start.
    task automatic model(input int s, input logic [W-1:0] d1, input logic [W-1:0] d2,
                         input int st1, input int st2, input int st3,
                         input int rst_at, input int ncyc, input logic stk);
        int           dv = div_of(s);
        int           wd = W * dv;
        int           t0 = -1000;
        logic [W-1:0] hold = '0;
        logic [W-1:0] q_seen;
        logic         m = last_match[s];
        for (int c = 0; c < ncyc; c++) begin
            int         rc = c - t0;
            logic       busy = 1'b0;
            logic       shf, dd, se, dn;
            logic [4:0] e;
            if (c == rst_at) begin
                t0 = -1000;
                m  = 1'b0;
                e  = '0;
            end else begin
                busy = (rc >= 1) && (rc <= 2 + wd);
                shf  = (rc >= 2) && (rc <= 1 + wd);
                dd   = shf ? hold[W - 1 - (rc - 2) / dv] : 1'b0;
                se   = shf && (((rc - 1) % dv) == 0);
                dn   = (rc == 3 + wd);
                if (dn) begin
                    q_seen = stk ? (hold & ~W'(1)) : hold;
                    m = (q_seen == hold);
                end
                e = {busy, dd, se, dn, m};
            end
            check($sformatf("trace dut%0d cycle %0d {busy,d,shift_en,done,match}", s, c),
                  32'(tr[c]), 32'(e));
            if (c != rst_at && !busy && (c == 0 || c == st1 || c == st2 || c == st3)) begin
                t0   = c;
                hold = (c == 0) ? d1 : d2;
                m    = 1'b0;
            end
        end
        last_match[s] = m;
        if (rst_at >= 0 && rst_at < ncyc) last_match[1 - s] = 1'b0;
    endtask

    // Entered and left just after a rising edge; Start is always issued in cycle 0.
    task automatic run(input int s, input logic [W-1:0] d1, input logic [W-1:0] d2,
                       input int st1, input int st2, input int st3,
                       input int rst_at, input int ncyc, input logic stk);
        stuck_v[s] = stk;
        for (int c = 0; c < ncyc; c++) begin
            logic go2 = (c == st1) || (c == st2) || (c == st3);
            start_v[s] = (c == 0) || go2;
            din_v[s]   = (c == 0) ? d1 : (go2 ? d2 : W'($urandom));
            if (rst_at >= 0 && c == rst_at) rst_n = 1'b0;
            else if (rst_at >= 0 && c == rst_at + 1) rst_n = 1'b1;
            @(negedge clk);
            tr[c]  = (s == 0) ? obs0 : obs1;
            trq[c] = (s == 0) ? q0 : q1;
            @(posedge clk);
            #1;
        end
        start_v[s] = 1'b0;
        model(s, d1, d2, st1, st2, st3, rst_at, ncyc, stk);
    endtask

    task automatic find_done(input int k, input int ncyc, output int cyc);
        int seen = 0;
        cyc = -1;
        for (int c = 0; c < ncyc; c++) begin
            if (tr[c][1]) begin
                seen++;
                if (seen == k) begin
                    cyc = c;
                    break;
                end
            end
        end
    endtask

    initial begin
        int dc;
        for (int s = 0; s < 2; s++) begin
            start_v[s] = 1'b1;
            din_v[s]   = 4'b1111;
            stuck_v[s] = 1'b0;
            last_match[s] = 1'b0;
        end

        // Reset with Start held high: nothing may be captured.
        repeat (3) begin
            @(negedge clk);
            check("reset outputs dut0", 32'(obs0), 32'd0);
            check("reset outputs dut1", 32'(obs1), 32'd0);
        end
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("idle outputs dut0 cycle %0d", c), 32'(obs0), 32'd0);
            check($sformatf("idle outputs dut1 cycle %0d", c), 32'(obs1), 32'd0);
        end
        @(posedge clk); #1;

        tbl[0] = '{0, 4'b1011, 1'b0, 11, 1'b1};
        tbl[1] = '{0, 4'b1011, 1'b1, 11, 1'b0};
        tbl[2] = '{1, 4'b1001, 1'b0,  7, 1'b1};
        tbl[3] = '{0, 4'b0000, 1'b0, 11, 1'b1};
        tbl[4] = '{1, 4'b1110, 1'b1,  7, 1'b1};
        tbl[5] = '{0, 4'b1111, 1'b0, 11, 1'b1};
        for (int i = 0; i < 6; i++) begin
            int nc = (tbl[i].sel == 0) ? 14 : 10;
            run(tbl[i].sel, tbl[i].data, '0, -1, -1, -1, -1, nc, tbl[i].stuck);
            find_done(1, nc, dc);
            check($sformatf("vec%0d done cycle", i), 32'(dc), 32'(tbl[i].exp_done));
            check($sformatf("vec%0d match", i), 32'(tr[tbl[i].exp_done][0]), 32'(tbl[i].exp_match));
            if (!tbl[i].stuck)
                check($sformatf("vec%0d q_fb at done", i), 32'(trq[tbl[i].exp_done]), 32'(tbl[i].data));
        end

        // Starts while busy are dropped; the one on the Done cycle is taken.
        run(0, 4'b1011, 4'b0110, 4, 10, 11, -1, 25, 1'b0);
        find_done(1, 25, dc);
        check("repulse first done cycle", 32'(dc), 32'd11);
        find_done(2, 25, dc);
        check("repulse second done cycle", 32'(dc), 32'd22);
        check("repulse second q_fb", 32'(trq[22]), 32'(4'b0110));

        // Reset in cycle 6 aborts; a later Start runs to completion.
        run(0, 4'b1011, 4'b0101, 8, -1, -1, 6, 21, 1'b0);
        find_done(1, 21, dc);
        check("abort first done after restart", 32'(dc), 32'd19);
        find_done(2, 21, dc);
        check("abort no extra done", 32'(dc), -32'sd1);

        for (int i = 0; i < 20; i++) begin
            int s      = int'($urandom_range(0, 1));
            int wd     = W * div_of(s);
            int rst_at = (i % 5 == 4) ? int'($urandom_range(2, 1 + wd)) : -1;
            int st1    = (rst_at >= 0) ? -1 : int'($urandom_range(1, 2 + wd));
            run(s, W'($urandom), W'($urandom), st1, 3 + wd, -1, rst_at,
                2 * (3 + wd) + 2, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
